// File: rtl/adc_spi_resp.sv
// adc_spi_resp: SPI slave that answers as an 8-channel, 12-bit ADC128S-style
// converter. Each 16-bit frame carries a channel address on MOSI (word bits
// 13:11) and returns, on MISO, the result of the channel addressed in the
// previous frame (one-frame pipeline). Results live in 8 registers that a
// host port can overwrite.
//
// Parameters:
//   DATA_W   width of each channel result register
//   RST_VAL  reset base; channel n resets to RST_VAL+n
//   DEC_STEP decrement applied to the served channel after each frame
//            (only when AUTO_DEC_EN is defined)
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   SS_n, SCLK, MOSI   SPI inputs (SCLK idles high), synchronized into clk
//   MISO               SPI response bit
//   wr_en/wr_chnl/wr_data  host write port for the channel registers
//   frm_done           one-clk pulse after a complete 16-bit frame
//   frm_chnl           channel decoded from the last complete frame
//   frm_err            one-clk pulse when SS_n rises before 16 SCLK rises
//
// Build option: define AUTO_DEC_EN to decrement the served channel register
// by DEC_STEP at the end of each complete frame (host write wins).
module adc_spi_resp #(
  parameter int                 DATA_W   = 12,
  parameter logic [DATA_W-1:0]  RST_VAL  = 12'hC00,
  parameter logic [DATA_W-1:0]  DEC_STEP = 12'h010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic              wr_en,
  input  logic [2:0]        wr_chnl,
  input  logic [DATA_W-1:0] wr_data,
  output logic              frm_done,
  output logic [2:0]        frm_chnl,
  output logic              frm_err
);

`ifdef AUTO_DEC_EN
  localparam bit DEC_ON = 1'b1;
`else
  localparam bit DEC_ON = 1'b0;
`endif
  localparam logic [DATA_W-1:0] DEC_AMT = DEC_ON ? DEC_STEP : '0;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, state_nxt;

  // [1] is the synchronized level, [2] the previous level for edge detect
  logic [2:0] ss_sync, sclk_sync, mosi_sync;
  logic       ss_fall, ss_rise, sclk_rise, sclk_fall;

  logic [DATA_W-1:0] chreg [8];
  logic [2:0]        pending;
  logic [4:0]        bit_cnt;
  logic [15:0]       tx_shift;
  // Only bits 13:11 of the received word are ever decoded, so bits above 13
  // are simply dropped off the top of the shifter.
  logic [13:0]       rx_shift;
  logic              first_fall;
  logic              defer_start;
  logic              start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync   <= '1;
      sclk_sync <= '1;
      mosi_sync <= '0;
    end else begin
      ss_sync   <= {ss_sync[1:0], SS_n};
      sclk_sync <= {sclk_sync[1:0], SCLK};
      mosi_sync <= {mosi_sync[1:0], MOSI};
    end
  end

  assign ss_fall   = ss_sync[2] & ~ss_sync[1];
  assign ss_rise   = ~ss_sync[2] & ss_sync[1];
  assign sclk_rise = ~sclk_sync[2] & sclk_sync[1];
  assign sclk_fall = sclk_sync[2] & ~sclk_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    frm_done  = 1'b0;
    frm_err   = 1'b0;
    MISO      = 1'b0;
    case (state)
      IDLE: begin
        // a fall seen during DONE is replayed here via defer_start
        if (ss_fall || defer_start) begin
          start     = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        MISO = tx_shift[15] & ~ss_sync[1];
        if (ss_rise) begin
          if (bit_cnt == 5'd16) begin
            state_nxt = DONE;
          end else begin
            frm_err   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      DONE: begin
        frm_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      frm_chnl    <= '0;
      bit_cnt     <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      first_fall  <= 1'b0;
      defer_start <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tx_shift    <= 16'(chreg[pending]);
            rx_shift    <= '0;
            bit_cnt     <= '0;
            first_fall  <= 1'b1;
            defer_start <= 1'b0;
          end
        end
        SHIFT: begin
          if (sclk_rise && bit_cnt != 5'd16) begin
            rx_shift <= {rx_shift[12:0], mosi_sync[2]};
            bit_cnt  <= bit_cnt + 5'd1;
          end
          // the MSB is already on MISO for the first rise, so the first
          // fall of the frame leaves the shifter alone
          if (sclk_fall) begin
            if (first_fall) first_fall <= 1'b0;
            else            tx_shift   <= {tx_shift[14:0], 1'b0};
          end
        end
        DONE: begin
          pending     <= rx_shift[13:11];
          frm_chnl    <= rx_shift[13:11];
          defer_start <= ss_fall;
        end
        default: ;
      endcase
    end
  end

  // Decrement (zero when AUTO_DEC_EN is undefined) is applied before the host
  // write so a write to the same channel in the same clk takes precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++) chreg[i] <= RST_VAL + DATA_W'(i);
    end else begin
      if (state == DONE) chreg[pending] <= chreg[pending] - DEC_AMT;
      if (wr_en)         chreg[wr_chnl] <= wr_data;
    end
  end

endmodule

// File: tb/tb_adc_spi_resp.sv
module tb_adc_spi_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SS_n, SCLK, MOSI;
  logic        MISO;
  logic        wr_en;
  logic [2:0]  wr_chnl;
  logic [11:0] wr_data;
  logic        frm_done, frm_err;
  logic [2:0]  frm_chnl;

  adc_spi_resp #(.DATA_W(12), .RST_VAL(12'hC00), .DEC_STEP(12'h010)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .wr_en(wr_en), .wr_chnl(wr_chnl), .wr_data(wr_data),
    .frm_done(frm_done), .frm_chnl(frm_chnl), .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] miso;
    logic [2:0]  chnl;
    int          nbits;
  } exp_t;

  exp_t        sb_q[$];
  logic [11:0] model [8];
  logic [2:0]  m_pend;
  logic [2:0]  m_chnl;
  int          n_checks = 0;
  int          n_fail   = 0;

`ifdef AUTO_DEC_EN
  localparam logic [11:0] M_DEC = 12'h010;
`else
  localparam logic [11:0] M_DEC = 12'h000;
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model[i] = 12'hC00 + 12'(i);
    m_pend = '0;
    m_chnl = '0;
    sb_q.delete();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    wr_en = 1'b0; wr_chnl = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
  endtask

  task automatic host_write(input logic [2:0] ch, input logic [11:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_chnl = ch; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    model[ch] = d;
  endtask

  // Runs one frame of nbits SCLK periods; optionally issues a host write
  // while bit 4 is being transferred.
  task automatic do_frame(input logic [15:0] cmd, input int nbits,
                          input bit do_wr, input logic [2:0] wch, input logic [11:0] wdat);
    exp_t        e, p;
    logic [15:0] got;
    logic [2:0]  served;
    int          nd, ne;
    e.miso  = {4'b0, model[m_pend]};
    e.chnl  = (nbits == 16) ? cmd[13:11] : m_chnl;
    e.nbits = nbits;
    sb_q.push_back(e);
    served = m_pend;
    got = '0;
    @(negedge clk);
    SS_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = cmd[15-i];
      if (do_wr && i == 4) begin
        wr_en = 1'b1; wr_chnl = wch; wr_data = wdat;
        @(negedge clk);
        wr_en = 1'b0;
        model[wch] = wdat;
        repeat (7) @(negedge clk);
      end else begin
        repeat (8) @(negedge clk);
      end
      got  = {got[14:0], MISO};
      SCLK = 1'b1;
      repeat (8) @(negedge clk);
    end
    SS_n = 1'b1;
    nd = 0; ne = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      nd += int'(frm_done);
      ne += int'(frm_err);
    end
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 1, 0);
    end else begin
      p = sb_q.pop_front();
      check_val("miso_word", got, p.miso >> (16 - p.nbits));
      check_val("frm_chnl", frm_chnl, p.chnl);
      check_val("miso_idle", MISO, 0);
      if (p.nbits == 16) begin
        check_val("done_cnt", nd, 1);
        check_val("err_cnt", ne, 0);
        model[served] = model[served] - M_DEC;
        m_pend = cmd[13:11];
        m_chnl = cmd[13:11];
      end else begin
        check_val("abort_done_cnt", nd, 0);
        check_val("abort_err_cnt", ne, 1);
      end
    end
  endtask

  initial begin
    logic [15:0] rc;
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    wr_en = 1'b0; wr_chnl = '0; wr_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_val("rst_miso", MISO, 0);
    check_val("rst_done", frm_done, 0);
    check_val("rst_err", frm_err, 0);
    check_val("rst_chnl", frm_chnl, 0);
    apply_reset();

    // basic pipeline
    do_frame(16'h1800, 16, 0, '0, '0);
    do_frame(16'h2800, 16, 0, '0, '0);
    do_frame(16'h0000, 16, 0, '0, '0);

    // host write, then mid-frame write to the channel being served
    host_write(3'd2, 12'hABC);
    do_frame(16'h1000, 16, 0, '0, '0);
    do_frame(16'h1000, 16, 0, '0, '0);
    do_frame(16'h1000, 16, 1, 3'd2, 12'h123);
    do_frame(16'h2000, 16, 0, '0, '0);

    // aborted frame with pending channel 4
    do_frame(16'h0800, 8, 0, '0, '0);
    do_frame(16'h0000, 16, 0, '0, '0);

`ifdef AUTO_DEC_EN
    apply_reset();
    do_frame(16'h0000, 16, 0, '0, '0);
    do_frame(16'h0000, 16, 0, '0, '0);
    host_write(3'd0, 12'h005);
    do_frame(16'h0000, 16, 0, '0, '0);
    do_frame(16'h0000, 16, 0, '0, '0);
`endif

    // random frames with occasional host writes
    for (int n = 0; n < 6; n++) begin
      rc = 16'($urandom);
      if ($urandom_range(1, 0) == 1) host_write(3'($urandom_range(7, 0)), 12'($urandom));
      do_frame(rc, 16, 0, '0, '0);
    end

    // reset in the middle of a frame
    host_write(m_pend, 12'hFFF);
    @(negedge clk);
    SS_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      SCLK = 1'b0; MOSI = 1'b1;
      repeat (8) @(negedge clk);
      SCLK = 1'b1;
      repeat (8) @(negedge clk);
    end
    check_val("pre_rst_miso", MISO, 1);
    rst_n = 1'b0;
    #1;
    check_val("async_rst_miso", MISO, 0);
    check_val("async_rst_err", frm_err, 0);
    check_val("async_rst_done", frm_done, 0);
    SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("post_rst_chnl", frm_chnl, 0);
    do_frame(16'h0000, 16, 0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
